// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the APB master command port.
// Latency: grant and command valid one edge after request; result plus done XFER_CYCLES edges later.
// Backpressure: requesters hold req/command until done; requests are not sampled outside IDLE.
module apb_rr_arbiter #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int XFER_CYCLES = 4
) (
    input  logic                  apb_clk,
    input  logic                  apb_resetn,
    input  logic                  m0_req,
    input  logic                  m0_wr_rd,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_done,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_slverr,
    input  logic                  m1_req,
    input  logic                  m1_wr_rd,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_done,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_slverr,
    output logic [ADDR_WIDTH-1:0] apb_addr,
    output logic [DATA_WIDTH-1:0] apb_wdata,
    output logic                  apb_wr_rd,
    input  logic [DATA_WIDTH-1:0] apb_rdata,
    input  logic                  apb_slverr
);

    localparam int CNT_W = (XFER_CYCLES > 2) ? $clog2(XFER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XFER_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt_q;
    logic                    last_grant_q;
    logic                    winner_q;
    logic                    win;
    logic                    grant_en;
    logic                    finish;
    logic [1:0]              gnt_q;
    logic [1:0]              done_q;
    logic [DATA_WIDTH-1:0]   rdata_q [2];
    logic [1:0]              slverr_q;

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_done   = done_q[0];
    assign m1_done   = done_q[1];
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign m0_slverr = slverr_q[0];
    assign m1_slverr = slverr_q[1];

    // Next-state and strobes; on a tie the requester not served last wins.
    always_comb begin
        state_nxt = state_q;
        grant_en  = 1'b0;
        finish    = 1'b0;
        win       = (m0_req & m1_req) ? ~last_grant_q : m1_req;
        case (state_q)
            IDLE: begin
                if (m0_req | m1_req) begin
                    grant_en  = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (cnt_q == '0) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge apb_clk or negedge apb_resetn) begin
        if (!apb_resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Command latch, window counter, result capture and per-requester outputs.
    always_ff @(posedge apb_clk or negedge apb_resetn) begin
        if (!apb_resetn) begin
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            gnt_q        <= '0;
            done_q       <= '0;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
            slverr_q     <= '0;
            apb_addr     <= '0;
            apb_wdata    <= '0;
            apb_wr_rd    <= 1'b0;
        end else begin
            done_q <= '0;
            if (grant_en) begin
                winner_q  <= win;
                gnt_q     <= {win, ~win};
                cnt_q     <= CNT_INIT;
                apb_addr  <= win ? m1_addr  : m0_addr;
                apb_wdata <= win ? m1_wdata : m0_wdata;
                apb_wr_rd <= win ? m1_wr_rd : m0_wr_rd;
            end else if (state_q == XFER) begin
                if (finish) begin
                    gnt_q              <= '0;
                    done_q[winner_q]   <= 1'b1;
                    slverr_q[winner_q] <= apb_slverr;
                    last_grant_q       <= winner_q;
                    // Writes leave the requester's last read data in place.
                    if (!apb_wr_rd) begin
                        rdata_q[winner_q] <= apb_rdata;
                    end
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
module tb_apb_rr_arbiter;

    logic        apb_clk;
    logic        apb_resetn;
    logic        m0_req, m0_wr_rd, m0_gnt, m0_done, m0_slverr;
    logic [9:0]  m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_wr_rd, m1_gnt, m1_done, m1_slverr;
    logic [9:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic [9:0]  apb_addr;
    logic [31:0] apb_wdata, apb_rdata;
    logic        apb_wr_rd, apb_slverr;

    int n_vec  = 0;
    int n_miss = 0;

    // Small slave model: 16-word memory, address 0x3FF answers with an error.
    logic [31:0] mem [16] = '{default: 32'h0};

    assign apb_rdata  = mem[apb_addr[3:0]];
    assign apb_slverr = (apb_addr == 10'h3FF);

    always @(negedge apb_clk) begin
        if ((m0_gnt || m1_gnt) && apb_wr_rd)
            mem[apb_addr[3:0]] <= apb_wdata;
    end

    apb_rr_arbiter #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .XFER_CYCLES(4)
    ) dut (
        .apb_clk   (apb_clk),
        .apb_resetn(apb_resetn),
        .m0_req    (m0_req),
        .m0_wr_rd  (m0_wr_rd),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_done   (m0_done),
        .m0_rdata  (m0_rdata),
        .m0_slverr (m0_slverr),
        .m1_req    (m1_req),
        .m1_wr_rd  (m1_wr_rd),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_done   (m1_done),
        .m1_rdata  (m1_rdata),
        .m1_slverr (m1_slverr),
        .apb_addr  (apb_addr),
        .apb_wdata (apb_wdata),
        .apb_wr_rd (apb_wr_rd),
        .apb_rdata (apb_rdata),
        .apb_slverr(apb_slverr)
    );

    initial apb_clk = 1'b0;
    always #5 apb_clk = ~apb_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until the given done output is seen; -1 if it never comes.
    task automatic wait_done(input int who, input int limit, output int cyc);
        cyc = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge apb_clk);
            cyc++;
            if ((who == 0 && m0_done) || (who == 1 && m1_done)) return;
        end
        cyc = -1;
    endtask

    function automatic logic any_out();
        return |{apb_addr, apb_wdata, apb_wr_rd,
                 m0_gnt, m0_done, m0_rdata, m0_slverr,
                 m1_gnt, m1_done, m1_rdata, m1_slverr};
    endfunction

    initial begin
        int cyc;
        int g0, g1, n;
        int order [4];
        logic overlap;

        apb_resetn = 1'b0;
        m0_req = 0; m0_wr_rd = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_wr_rd = 0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(negedge apb_clk);
        check("reset_outputs", 64'(any_out()), 64'd0);
        apb_resetn = 1'b1;
        @(negedge apb_clk);

        // m0 write 0xDEADBEEF to address 3
        m0_req = 1; m0_wr_rd = 1; m0_addr = 10'd3; m0_wdata = 32'hDEADBEEF;
        @(negedge apb_clk);
        check("t1_gnt", 64'(m0_gnt), 64'd1);
        check("t1_addr", 64'(apb_addr), 64'd3);
        check("t1_wr_rd", 64'(apb_wr_rd), 64'd1);
        check("t1_wdata", 64'(apb_wdata), 64'hDEADBEEF);
        check("t1_m1_gnt", 64'(m1_gnt), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge apb_clk);
            check("t1_gnt_hold", 64'({m0_gnt, m0_done}), 64'b10);
        end
        @(negedge apb_clk);
        check("t1_done", 64'({m0_gnt, m0_done}), 64'b01);
        check("t1_rdata", 64'(m0_rdata), 64'd0);
        m0_req = 0;
        @(negedge apb_clk);
        check("t1_done_low", 64'(m0_done), 64'd0);
        check("t1_idle_hold_addr", 64'(apb_addr), 64'd3);

        // m0 read back address 3
        m0_req = 1; m0_wr_rd = 0; m0_addr = 10'd3; m0_wdata = '0;
        wait_done(0, 12, cyc);
        check("t2_latency", 64'(cyc), 64'd5);
        check("t2_rdata", 64'(m0_rdata), 64'hDEADBEEF);
        check("t2_slverr", 64'(m0_slverr), 64'd0);
        check("t2_m1_quiet", 64'({m1_gnt, m1_done, m1_rdata, m1_slverr}), 64'd0);
        m0_req = 0;
        @(negedge apb_clk);

        // m1 read of the error address, then a clean read clears slverr
        m1_req = 1; m1_wr_rd = 0; m1_addr = 10'h3FF;
        wait_done(1, 12, cyc);
        check("t3_err_latency", 64'(cyc), 64'd5);
        check("t3_slverr_set", 64'(m1_slverr), 64'd1);
        check("t3_m0_unchanged", 64'({m0_rdata, m0_slverr}), {31'd0, 32'hDEADBEEF, 1'b0});
        m1_req = 0;
        @(negedge apb_clk);
        m1_req = 1; m1_addr = 10'd3;
        wait_done(1, 12, cyc);
        check("t3_slverr_clr", 64'(m1_slverr), 64'd0);
        check("t3_rdata", 64'(m1_rdata), 64'hDEADBEEF);
        m1_req = 0;
        @(negedge apb_clk);

        // simultaneous writes: m0 first, m1 six cycles later
        m0_req = 1; m0_wr_rd = 1; m0_addr = 10'd1; m0_wdata = 32'h11111111;
        m1_req = 1; m1_wr_rd = 1; m1_addr = 10'd2; m1_wdata = 32'h22222222;
        g0 = -1; g1 = -1; overlap = 1'b0;
        for (int c = 1; c <= 20 && (m0_req || m1_req); c++) begin
            @(negedge apb_clk);
            if (m0_gnt && g0 < 0) g0 = c;
            if (m1_gnt && g1 < 0) g1 = c;
            if ((m0_gnt && m1_gnt) || (m0_done && m1_done)) overlap = 1'b1;
            if (m0_done) m0_req = 0;
            if (m1_done) m1_req = 0;
        end
        check("t4_m0_first", 64'(g0), 64'd1);
        check("t4_m1_gap", 64'(g1), 64'd7);
        check("t4_no_overlap", 64'(overlap), 64'd0);
        m0_req = 0; m1_req = 0;
        @(negedge apb_clk);

        // both held requesting: strict alternation
        m0_req = 1; m0_wr_rd = 0; m0_addr = 10'd1;
        m1_req = 1; m1_wr_rd = 0; m1_addr = 10'd2;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge apb_clk);
            if (m0_done) begin order[n] = 0; n++; end
            else if (m1_done) begin order[n] = 1; n++; end
        end
        m0_req = 0; m1_req = 0;
        check("t5_count", 64'(n), 64'd4);
        check("t5_order", 64'({order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}),
              64'b00_01_00_01);
        check("t5_m0_rdata", 64'(m0_rdata), 64'h11111111);
        check("t5_m1_rdata", 64'(m1_rdata), 64'h22222222);
        @(negedge apb_clk);

        // reset in the 2nd XFER cycle aborts the transfer
        m0_req = 1; m0_wr_rd = 0; m0_addr = 10'd1;
        @(negedge apb_clk);
        check("t6_gnt", 64'(m0_gnt), 64'd1);
        @(negedge apb_clk);
        apb_resetn = 1'b0;
        #1;
        check("t6_abort_outputs", 64'(any_out()), 64'd0);
        m1_req = 1; m1_wr_rd = 0; m1_addr = 10'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge apb_clk);
            check("t6_no_done", 64'({m0_done, m1_done}), 64'd0);
        end
        apb_resetn = 1'b1;
        @(negedge apb_clk);
        check("t6_tie_after_reset", 64'({m1_gnt, m0_gnt}), 64'b01);
        wait_done(0, 10, cyc);
        check("t6_m0_latency", 64'(cyc), 64'd4);
        check("t6_m0_rdata", 64'(m0_rdata), 64'h11111111);
        m0_req = 0;
        wait_done(1, 12, cyc);
        check("t6_m1_served", 64'(cyc > 0), 64'd1);
        check("t6_m1_rdata", 64'(m1_rdata), 64'h22222222);
        m1_req = 0;
        @(negedge apb_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
